// File: rtl/c_pipe_pkg.sv
// Shared load/ALU pipeline types: default widths, post-op encodings, load request struct.
// Combinational definitions only; no latency or flow control of its own.
package c_pipe_pkg;

  localparam int C_AW = 8;
  localparam int C_DW = 16;
  localparam int C_RW = 4;

  localparam logic [3:0] FN_PASS  = 4'd0;
  localparam logic [3:0] FN_ZXLO  = 4'd1;
  localparam logic [3:0] FN_ZXHI  = 4'd2;
  localparam logic [3:0] FN_SXLO  = 4'd3;
  localparam logic [3:0] FN_SRL1  = 4'd4;
  localparam logic [3:0] FN_SLL1  = 4'd5;
  localparam logic [3:0] FN_NEG   = 4'd6;
  localparam logic [3:0] FN_BSWAP = 4'd7;

  typedef struct packed {
    logic [C_AW-1:0] addr;
    logic [C_RW-1:0] rd;
    logic [3:0]      func;
  } load_req_t;

endpackage

// File: rtl/c_load_postop.sv
// Load post-op: combinational transform of the loaded word, zero latency, no flow control.
// Unsupported func codes yield zero data with err set; the beat itself is never dropped.
module c_load_postop
  import c_pipe_pkg::*;
#(
  parameter int DW = C_DW
) (
  input  logic [DW-1:0] din,
  input  logic [3:0]    func,
  output logic [DW-1:0] dout,
  output logic          err
);

  always_comb begin
    dout = '0;
    err  = 1'b0;
    case (func)
      FN_PASS:  dout = din;
      FN_ZXLO:  dout = {{(DW-8){1'b0}}, din[7:0]};
      FN_ZXHI:  dout = {{(DW-8){1'b0}}, din[DW-1:DW-8]};
      FN_SXLO:  dout = {{(DW-8){din[7]}}, din[7:0]};
      FN_SRL1:  dout = din >> 1;
      FN_SLL1:  dout = din << 1;
      FN_NEG:   dout = '0 - din;
      FN_BSWAP: dout = {din[7:0], din[DW-1:8]};
      default:  err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/c_load_pipeline.sv
// 3-stage load unit over a private 256x16 memory; rsp_valid 3 cycles after the handshake cycle.
// Whole pipe stalls on rsp_valid & ~rsp_ready (req_ready drops); C_LOAD_FWD_EN forwards same-cycle stores into S2.
module c_load_pipeline
  import c_pipe_pkg::*;
#(
  parameter int AW = C_AW,
  parameter int DW = C_DW,
  parameter int RW = C_RW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [RW-1:0] req_rd,
  input  logic [3:0]    req_func,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [RW-1:0] rsp_rd,
  output logic          rsp_err,
  output logic          rf_we
);

  logic [DW-1:0] mem [2**AW];

  logic          s1_vld;
  load_req_t     s1_req;
  logic          s2_vld;
  logic [DW-1:0] s2_dat;
  logic [RW-1:0] s2_rd;
  logic [3:0]    s2_func;

  logic          stall, s1_en, s2_en, s3_en, accept;
  logic [DW-1:0] rd_dat, post_dat;
  logic          post_err;

  // Each stage refills when its successor is empty or moving, so bubbles squeeze out under stall.
  assign stall     = rsp_valid & ~rsp_ready;
  assign s3_en     = ~stall;
  assign s2_en     = ~s2_vld | s3_en;
  assign s1_en     = ~s1_vld | s2_en;
  assign req_ready = ~stall;
  assign accept    = req_valid & req_ready;
  assign rf_we     = rsp_valid & rsp_ready;

`ifdef C_LOAD_FWD_EN
  assign rd_dat = (mem_we && (mem_waddr == s1_req.addr)) ? mem_wdata : mem[s1_req.addr];
`else
  assign rd_dat = mem[s1_req.addr];
`endif

  // Store port is never gated by the pipeline stall; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  c_load_postop #(.DW(DW)) u_postop (
    .din  (s2_dat),
    .func (s2_func),
    .dout (post_dat),
    .err  (post_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_req    <= '0;
      s2_vld    <= 1'b0;
      s2_dat    <= '0;
      s2_rd     <= '0;
      s2_func   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_rd    <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (s1_en) s1_vld <= accept;
      if (accept) s1_req <= '{addr: req_addr, rd: req_rd, func: req_func};
      if (s2_en) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_dat  <= rd_dat;
          s2_rd   <= s1_req.rd;
          s2_func <= s1_req.func;
        end
      end
      if (s3_en) begin
        rsp_valid <= s2_vld;
        if (s2_vld) begin
          rsp_data <= post_dat;
          rsp_rd   <= s2_rd;
          rsp_err  <= post_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_c_load_pipeline.sv
// Directed bench for c_load_pipeline: latency, post-ops, backpressure, store hazard, error func, reset.
module tb_c_load_pipeline;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [7:0]  req_addr;
  logic [3:0]  req_rd, req_func;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_rd;
  logic        rsp_err, rf_we;

  c_load_pipeline dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_rd    (req_rd),
    .req_func  (req_func),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_rd    (rsp_rd),
    .rsp_err   (rsp_err),
    .rf_we     (rf_we)
  );

  typedef struct {
    logic [15:0] d;
    logic [3:0]  rd;
    logic        err;
    int          cyc;
  } beat_t;

  beat_t q[$];
  int    errs = 0;
  int    checks = 0;
  int    cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Every accepted beat is logged; rf_we must track the handshake.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      check("rf_we", {31'd0, rf_we}, {31'd0, rsp_ready});
      if (rsp_ready) q.push_back('{d: rsp_data, rd: rsp_rd, err: rsp_err, cyc: cyc});
    end
  end

  task automatic send(input logic [7:0] a, input logic [3:0] rd, input logic [3:0] fn);
    logic ok;
    int   b;
    req_valid = 1'b1; req_addr = a; req_rd = rd; req_func = fn;
    b = 0;
    do begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
      b++;
    end while (!ok && b < 60);
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic store(input logic [7:0] a, input logic [15:0] d);
    mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
    @(posedge clk); #1;
    mem_we = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n);
    int b;
    b = 0;
    while (q.size() < n && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    check(tag, q.size(), n);
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [15:0] d,
                          input logic [3:0] rd, input logic err);
    if (i < q.size()) begin
      check({tag, "_data"}, q[i].d, d);
      check({tag, "_rd"}, q[i].rd, rd);
      check({tag, "_err"}, q[i].err, err);
    end else begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    logic [15:0] hz_exp;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_rd = '0; req_func = '0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0; rsp_ready = 1'b1;
    #3;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_rd", rsp_rd, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rf_we", rf_we, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_req_ready", req_ready, 1);

    // Preload and single load: result 3 cycles after the handshake cycle.
    store(8'd125, 16'h00F3);
    store(8'd126, 16'h80FF);
    store(8'd127, 16'h0001);
    base = q.size();
    k = cyc;
    send(8'd125, 4'd10, 4'd0);
    req_valid = 1'b0;
    wait_beats("lat_beats", base + 1);
    chk_beat("lat", base, 16'h00F3, 4'd10, 1'b0);
    if (q.size() > base) check("lat_cycles", q[base].cyc - k, 3);
    repeat (4) @(posedge clk);
    #1 check("lat_single_pulse", q.size(), base + 1);

    // Back-to-back post-ops on 16'h80FF.
    base = q.size();
    k = cyc;
    send(8'd126, 4'd1, 4'd1);
    send(8'd126, 4'd2, 4'd3);
    send(8'd126, 4'd3, 4'd7);
    send(8'd126, 4'd4, 4'd6);
    req_valid = 1'b0;
    wait_beats("b2b_beats", base + 4);
    chk_beat("b2b_zxlo", base,     16'h00FF, 4'd1, 1'b0);
    chk_beat("b2b_sxlo", base + 1, 16'hFFFF, 4'd2, 1'b0);
    chk_beat("b2b_bswap", base + 2, 16'hFF80, 4'd3, 1'b0);
    chk_beat("b2b_neg", base + 3, 16'h7F01, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++)
      if (base + i < q.size()) check("b2b_cycle", q[base+i].cyc - k, 3 + i);

    // Backpressure: the consumer refuses the first beat for several cycles.
    base = q.size();
    rsp_ready = 1'b0;
    fork
      begin
        send(8'd125, 4'd1, 4'd0);
        send(8'd125, 4'd2, 4'd4);
        send(8'd125, 4'd3, 4'd5);
        send(8'd125, 4'd4, 4'd2);
        req_valid = 1'b0;
      end
      begin
        int b;
        b = 0;
        while (!rsp_valid && b < 50) begin @(negedge clk); b++; end
        repeat (5) @(negedge clk);
        check("bp_req_ready", req_ready, 0);
        check("bp_held_rd", rsp_rd, 1);
        check("bp_held_data", rsp_data, 16'h00F3);
        @(posedge clk); #2;
        rsp_ready = 1'b1;
      end
    join
    wait_beats("bp_beats", base + 4);
    chk_beat("bp0", base,     16'h00F3, 4'd1, 1'b0);
    chk_beat("bp1", base + 1, 16'h0079, 4'd2, 1'b0);
    chk_beat("bp2", base + 2, 16'h01E6, 4'd3, 1'b0);
    chk_beat("bp3", base + 3, 16'h0000, 4'd4, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("bp_no_dup", q.size(), base + 4);

    // Store to the same address on the edge the load moves from S1 to S2.
`ifdef C_LOAD_FWD_EN
    hz_exp = 16'h1234;
`else
    hz_exp = 16'h0001;
`endif
    base = q.size();
    send(8'd127, 4'd5, 4'd0);
    req_valid = 1'b0;
    store(8'd127, 16'h1234);
    wait_beats("hz_beats", base + 1);
    chk_beat("hz", base, hz_exp, 4'd5, 1'b0);
    send(8'd127, 4'd6, 4'd0);
    req_valid = 1'b0;
    wait_beats("hz_later_beats", base + 2);
    chk_beat("hz_later", base + 1, 16'h1234, 4'd6, 1'b0);

    // Unsupported func still delivers a beat.
    base = q.size();
    send(8'd125, 4'd9, 4'd12);
    req_valid = 1'b0;
    wait_beats("err_beats", base + 1);
    chk_beat("err", base, 16'h0000, 4'd9, 1'b1);

    // Reset with three loads in flight.
    base = q.size();
    send(8'd125, 4'd1, 4'd0);
    send(8'd126, 4'd2, 4'd0);
    send(8'd127, 4'd3, 4'd0);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_data", rsp_data, 0);
    check("arst_rf_we", rf_we, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("arst_no_stale", q.size(), base);
    check("arst_idle_valid", rsp_valid, 0);
    send(8'd127, 4'd7, 4'd0);
    send(8'd126, 4'd8, 4'd0);
    req_valid = 1'b0;
    wait_beats("arst_retain_beats", base + 2);
    chk_beat("arst_mem127", base,     16'h1234, 4'd7, 1'b0);
    chk_beat("arst_mem126", base + 1, 16'h80FF, 4'd8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
